// File: rtl/res_st_sched_pkg.sv
// Shared types and sizing for the reservation-station scheduler.
package res_st_sched_pkg;

    localparam int RES_ST_SIZE        = 8;
    localparam int PHY_RF_ADDR_WIDTH  = 6;
    localparam int ROB_SIZE           = 32;
    localparam int RES_ST_ADDR_WIDTH  = $clog2(RES_ST_SIZE);
    localparam int ROB_ADDR_WIDTH     = $clog2(ROB_SIZE);

    typedef logic [RES_ST_ADDR_WIDTH-1:0] res_st_addr_t;
    typedef logic [ROB_ADDR_WIDTH-1:0]    rob_addr_t;
    typedef logic [PHY_RF_ADDR_WIDTH-1:0] phy_tag_t;

    // Per-entry lifecycle: FREE -> WAIT (written) -> SEL (in issue reg) -> FREE
    typedef enum logic [1:0] {
        FREE = 2'd0,
        WAIT = 2'd1,
        SEL  = 2'd2
    } res_st_entry_state_t;

    // Distance from the ROB head; the ROB_SIZE wrap falls out of the width.
    function automatic rob_addr_t rob_age(rob_addr_t tag, rob_addr_t head);
        return tag - head;
    endfunction

endpackage

// File: rtl/res_st_sched_if.sv
// Rename-side and execute-side bus of the reservation-station scheduler.
//
// Issue handshake: issue_valid_out / issue_ready_in. A transfer happens on
// every rising edge where both are 1. While valid=1 and ready=0 the issue
// address and ROB tag are held stable; valid never drops without a transfer
// except on flush or reset.
interface res_st_sched_if;
    import res_st_sched_pkg::*;

    logic         free_slot_valid_out;
    res_st_addr_t free_slot_addr_out;
    logic         res_st_wr_en_in;
    res_st_addr_t res_st_wr_addr_in;
    phy_tag_t     src1_tag_in;
    logic         src1_busy_in;
    phy_tag_t     src2_tag_in;
    logic         src2_busy_in;
    rob_addr_t    rob_tag_in;
    logic         issue_valid_out;
    res_st_addr_t issue_addr_out;
    rob_addr_t    issue_rob_tag_out;
    logic         issue_ready_in;
    res_st_entry_state_t [RES_ST_SIZE-1:0] entry_state_dbg;

    modport slave (
        output free_slot_valid_out, free_slot_addr_out,
        input  res_st_wr_en_in, res_st_wr_addr_in,
        input  src1_tag_in, src1_busy_in, src2_tag_in, src2_busy_in, rob_tag_in,
        output issue_valid_out, issue_addr_out, issue_rob_tag_out,
        input  issue_ready_in,
        output entry_state_dbg
    );

    modport master (
        input  free_slot_valid_out, free_slot_addr_out,
        output res_st_wr_en_in, res_st_wr_addr_in,
        output src1_tag_in, src1_busy_in, src2_tag_in, src2_busy_in, rob_tag_in,
        input  issue_valid_out, issue_addr_out, issue_rob_tag_out,
        output issue_ready_in,
        input  entry_state_dbg
    );

endinterface

// File: rtl/res_st_sched_age_select.sv
// Oldest-ready picker: minimum (rob_tag - head) among ready entries,
// ties resolved toward the lowest index.
module res_st_sched_age_select
    import res_st_sched_pkg::*;
(
    input  logic [RES_ST_SIZE-1:0] ready,
    input  rob_addr_t              rob_tags [RES_ST_SIZE],
    input  rob_addr_t              head,
    output logic                   sel_valid,
    output res_st_addr_t           sel_idx
);

    rob_addr_t best_age;

    // Ascending scan with strict less-than keeps the lowest index on ties
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < RES_ST_SIZE; i++) begin
            if (ready[i] && (!sel_valid || rob_age(rob_tags[i], head) < best_age)) begin
                sel_valid = 1'b1;
                sel_idx   = res_st_addr_t'(i);
                best_age  = rob_age(rob_tags[i], head);
            end
        end
    end

endmodule

// File: rtl/res_st_sched.sv
// Reservation-station occupancy tracking, CDB wakeup and oldest-ready issue.
module res_st_sched
    import res_st_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    res_st_sched_if.slave       rs,
    input  rob_addr_t           rob_head_ptr_in,
    input  logic                cdb_valid_in,
    input  phy_tag_t            cdb_tag_in,
    input  logic                flush_in,
    output logic                err_out
);

    res_st_entry_state_t [RES_ST_SIZE-1:0] state_q;
    logic [RES_ST_SIZE-1:0] src1_busy_q;
    logic [RES_ST_SIZE-1:0] src2_busy_q;
    phy_tag_t               src1_tag_q [RES_ST_SIZE];
    phy_tag_t               src2_tag_q [RES_ST_SIZE];
    rob_addr_t              rob_tag_q  [RES_ST_SIZE];

    logic         issue_valid_q;
    res_st_addr_t issue_addr_q;
    rob_addr_t    issue_rob_tag_q;
    logic         err_q;

    logic [RES_ST_SIZE-1:0] ready;
    logic         sel_valid;
    res_st_addr_t sel_idx;
    logic         fire;
    logic         load;
    logic         wr_ok;

    assign fire  = issue_valid_q & rs.issue_ready_in;
    assign load  = sel_valid & (~issue_valid_q | fire);
    assign wr_ok = rs.res_st_wr_en_in & (state_q[rs.res_st_wr_addr_in] == FREE);

    // Readiness from registered state only: eligible the cycle after the last busy bit clears
    always_comb begin
        for (int i = 0; i < RES_ST_SIZE; i++) begin
            ready[i] = (state_q[i] == WAIT) & ~src1_busy_q[i] & ~src2_busy_q[i];
        end
    end

    res_st_sched_age_select u_age_select (
        .ready     (ready),
        .rob_tags  (rob_tag_q),
        .head      (rob_head_ptr_in),
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx)
    );

    // Lowest-index FREE entry advertised to rename
    always_comb begin
        rs.free_slot_valid_out = 1'b0;
        rs.free_slot_addr_out  = '0;
        for (int i = RES_ST_SIZE - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) begin
                rs.free_slot_valid_out = 1'b1;
                rs.free_slot_addr_out  = res_st_addr_t'(i);
            end
        end
    end

    // Entry lifecycle, operand capture with CDB bypass, and wakeup
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RES_ST_SIZE; i++) begin
                state_q[i]     <= FREE;
                src1_busy_q[i] <= 1'b0;
                src2_busy_q[i] <= 1'b0;
                src1_tag_q[i]  <= '0;
                src2_tag_q[i]  <= '0;
                rob_tag_q[i]   <= '0;
            end
        end else if (flush_in) begin
            for (int i = 0; i < RES_ST_SIZE; i++) begin
                state_q[i] <= FREE;
            end
        end else begin
            for (int i = 0; i < RES_ST_SIZE; i++) begin
                if (state_q[i] == SEL && fire && issue_addr_q == res_st_addr_t'(i)) begin
                    state_q[i] <= FREE;
                end else if (state_q[i] == WAIT && load && sel_idx == res_st_addr_t'(i)) begin
                    state_q[i] <= SEL;
                end else if (wr_ok && rs.res_st_wr_addr_in == res_st_addr_t'(i)) begin
                    state_q[i]     <= WAIT;
                    src1_tag_q[i]  <= rs.src1_tag_in;
                    src2_tag_q[i]  <= rs.src2_tag_in;
                    rob_tag_q[i]   <= rs.rob_tag_in;
                    src1_busy_q[i] <= rs.src1_busy_in &
                                      ~(cdb_valid_in && cdb_tag_in == rs.src1_tag_in);
                    src2_busy_q[i] <= rs.src2_busy_in &
                                      ~(cdb_valid_in && cdb_tag_in == rs.src2_tag_in);
                end
                if (state_q[i] == WAIT && cdb_valid_in) begin
                    if (src1_tag_q[i] == cdb_tag_in) src1_busy_q[i] <= 1'b0;
                    if (src2_tag_q[i] == cdb_tag_in) src2_busy_q[i] <= 1'b0;
                end
            end
        end
    end

    // Issue register: reload on empty or on transfer, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid_q   <= 1'b0;
            issue_addr_q    <= '0;
            issue_rob_tag_q <= '0;
        end else if (flush_in) begin
            issue_valid_q <= 1'b0;
        end else if (load) begin
            issue_valid_q   <= 1'b1;
            issue_addr_q    <= sel_idx;
            issue_rob_tag_q <= rob_tag_q[sel_idx];
        end else if (fire) begin
            issue_valid_q <= 1'b0;
        end
    end

    // Sticky flag for writes aimed at an occupied entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (!flush_in && rs.res_st_wr_en_in && !wr_ok) begin
            err_q <= 1'b1;
        end
    end

    assign rs.issue_valid_out   = issue_valid_q;
    assign rs.issue_addr_out    = issue_addr_q;
    assign rs.issue_rob_tag_out = issue_rob_tag_q;
    assign rs.entry_state_dbg   = state_q;
    assign err_out              = err_q;

endmodule

// File: tb/tb_res_st_sched.sv
// Directed and random checks of res_st_sched against a slot-table model.
module tb_res_st_sched;
    import res_st_sched_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    rob_addr_t head;
    logic      cdb_valid;
    phy_tag_t  cdb_tag;
    logic      flush;
    logic      err;

    int n_cmp = 0;
    int n_err = 0;

    res_st_sched_if rs();

    res_st_sched dut (
        .clk             (clk),
        .rst             (rst),
        .rs              (rs.slave),
        .rob_head_ptr_in (head),
        .cdb_valid_in    (cdb_valid),
        .cdb_tag_in      (cdb_tag),
        .flush_in        (flush),
        .err_out         (err)
    );

    always #5 clk = ~clk;

    // Model: a table of occupied slots, the one held for issue, and a sticky error
    bit m_used [RES_ST_SIZE];
    bit m_sel  [RES_ST_SIZE];
    bit m_b1   [RES_ST_SIZE];
    bit m_b2   [RES_ST_SIZE];
    int m_t1   [RES_ST_SIZE];
    int m_t2   [RES_ST_SIZE];
    int m_rob  [RES_ST_SIZE];
    bit m_iv;
    int m_ia;
    int m_irob;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < RES_ST_SIZE; i++) begin
            m_used[i] = 0; m_sel[i] = 0; m_b1[i] = 0; m_b2[i] = 0;
            m_t1[i] = 0; m_t2[i] = 0; m_rob[i] = 0;
        end
        m_iv = 0; m_ia = 0; m_irob = 0; m_err = 0;
    endtask

    // One clock edge of the model, using the inputs present before the edge
    task automatic model_edge();
        int pick, best, age, wa;
        bit fire, was_valid, wr_free;
        pick = -1;
        best = ROB_SIZE;
        for (int i = 0; i < RES_ST_SIZE; i++) begin
            if (m_used[i] && !m_sel[i] && !m_b1[i] && !m_b2[i]) begin
                age = (m_rob[i] - int'(head) + ROB_SIZE) % ROB_SIZE;
                if (age < best) begin
                    best = age;
                    pick = i;
                end
            end
        end
        was_valid = m_iv;
        fire = m_iv && rs.issue_ready_in;
        if (flush) begin
            for (int i = 0; i < RES_ST_SIZE; i++) begin
                m_used[i] = 0;
                m_sel[i]  = 0;
            end
            m_iv = 0;
            return;
        end
        wa = int'(rs.res_st_wr_addr_in);
        wr_free = !m_used[wa];
        if (cdb_valid) begin
            for (int i = 0; i < RES_ST_SIZE; i++) begin
                if (m_used[i] && !m_sel[i]) begin
                    if (m_t1[i] == int'(cdb_tag)) m_b1[i] = 0;
                    if (m_t2[i] == int'(cdb_tag)) m_b2[i] = 0;
                end
            end
        end
        if (fire) begin
            m_used[m_ia] = 0;
            m_sel[m_ia]  = 0;
            m_iv = 0;
        end
        if (rs.res_st_wr_en_in) begin
            if (wr_free) begin
                m_used[wa] = 1;
                m_sel[wa]  = 0;
                m_t1[wa]   = int'(rs.src1_tag_in);
                m_t2[wa]   = int'(rs.src2_tag_in);
                m_rob[wa]  = int'(rs.rob_tag_in);
                m_b1[wa]   = rs.src1_busy_in && !(cdb_valid && cdb_tag == rs.src1_tag_in);
                m_b2[wa]   = rs.src2_busy_in && !(cdb_valid && cdb_tag == rs.src2_tag_in);
            end else begin
                m_err = 1;
            end
        end
        if (pick >= 0 && (!was_valid || fire)) begin
            m_sel[pick] = 1;
            m_iv   = 1;
            m_ia   = pick;
            m_irob = m_rob[pick];
        end
    endtask

    task automatic check_all();
        bit exp_fv;
        int exp_fa;
        exp_fv = 0;
        exp_fa = 0;
        for (int i = RES_ST_SIZE - 1; i >= 0; i--) begin
            if (!m_used[i]) begin
                exp_fv = 1;
                exp_fa = i;
            end
        end
        chk("free_valid", rs.free_slot_valid_out, exp_fv);
        chk("free_addr", rs.free_slot_addr_out, exp_fa);
        chk("issue_valid", rs.issue_valid_out, m_iv);
        if (m_iv) begin
            chk("issue_addr", rs.issue_addr_out, m_ia);
            chk("issue_rob", rs.issue_rob_tag_out, m_irob);
        end
        chk("err", err, m_err);
    endtask

    // Advance one clock, then compare, then drop the one-cycle pulses
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        rs.res_st_wr_en_in = 0;
        cdb_valid = 0;
        flush = 0;
    endtask

    task automatic wr(input int addr, input int t1, input bit b1,
                      input int t2, input bit b2, input int rob);
        rs.res_st_wr_en_in   = 1;
        rs.res_st_wr_addr_in = res_st_addr_t'(addr);
        rs.src1_tag_in       = phy_tag_t'(t1);
        rs.src1_busy_in      = b1;
        rs.src2_tag_in       = phy_tag_t'(t2);
        rs.src2_busy_in      = b2;
        rs.rob_tag_in        = rob_addr_t'(rob);
    endtask

    task automatic cdb(input int tag);
        cdb_valid = 1;
        cdb_tag   = phy_tag_t'(tag);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_issue_valid"}, rs.issue_valid_out, 0);
        chk({tag, "_issue_addr"}, rs.issue_addr_out, 0);
        chk({tag, "_issue_rob"}, rs.issue_rob_tag_out, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_free_valid"}, rs.free_slot_valid_out, 1);
        chk({tag, "_free_addr"}, rs.free_slot_addr_out, 0);
    endtask

    initial begin
        int fa;
        rst = 1;
        head = '0;
        cdb_valid = 0;
        cdb_tag = '0;
        flush = 0;
        rs.res_st_wr_en_in = 0;
        rs.res_st_wr_addr_in = '0;
        rs.src1_tag_in = '0;
        rs.src1_busy_in = 0;
        rs.src2_tag_in = '0;
        rs.src2_busy_in = 0;
        rs.rob_tag_in = '0;
        rs.issue_ready_in = 0;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 0;

        // Ready write: free pointer moves next cycle, issue one cycle later
        rs.issue_ready_in = 1;
        wr(0, 0, 0, 0, 0, 3);
        step();
        chk("t1_free_addr", rs.free_slot_addr_out, 1);
        chk("t1_no_issue_yet", rs.issue_valid_out, 0);
        step();
        chk("t1_issue_valid", rs.issue_valid_out, 1);
        chk("t1_issue_addr", rs.issue_addr_out, 0);
        chk("t1_issue_rob", rs.issue_rob_tag_out, 3);
        step();
        step();

        // Busy operand waits for its CDB broadcast
        wr(0, 20, 1, 0, 0, 5);
        step();
        step();
        chk("t2_wait1", rs.issue_valid_out, 0);
        cdb(20);
        step();
        chk("t2_wait2", rs.issue_valid_out, 0);
        step();
        chk("t2_issue_valid", rs.issue_valid_out, 1);
        chk("t2_issue_rob", rs.issue_rob_tag_out, 5);
        step();
        step();

        // Age ordering across the ROB wrap: rob 30 (age 2) beats rob 1 (age 5)
        rs.issue_ready_in = 0;
        head = 28;
        wr(0, 9, 1, 0, 0, 30);
        step();
        wr(1, 9, 1, 0, 0, 1);
        step();
        cdb(9);
        step();
        step();
        chk("t3_first_addr", rs.issue_addr_out, 0);
        chk("t3_first_rob", rs.issue_rob_tag_out, 30);
        step();
        chk("t3_hold_addr", rs.issue_addr_out, 0);
        rs.issue_ready_in = 1;
        step();
        chk("t3_second_valid", rs.issue_valid_out, 1);
        chk("t3_second_addr", rs.issue_addr_out, 1);
        chk("t3_second_rob", rs.issue_rob_tag_out, 1);
        step();
        step();
        head = 0;

        // Fill all entries, then write again to slot 2
        for (int i = 0; i < RES_ST_SIZE; i++) begin
            wr(i, 40 + i, 1, 40 + i, 1, 10 + i);
            step();
        end
        chk("t4_full", rs.free_slot_valid_out, 0);
        wr(2, 11, 0, 11, 0, 7);
        step();
        chk("t4_err", err, 1);
        step();
        chk("t4_ignored", rs.issue_valid_out, 0);
        cdb(42);
        step();
        step();
        chk("t4_orig_rob", rs.issue_rob_tag_out, 12);
        step();
        step();

        // Flush with WAIT entries and one held in the issue register
        rs.issue_ready_in = 0;
        cdb(43);
        step();
        step();
        chk("t6_sel_before_flush", rs.issue_valid_out, 1);
        flush = 1;
        step();
        chk("t6_issue_cleared", rs.issue_valid_out, 0);
        chk("t6_free_valid", rs.free_slot_valid_out, 1);
        chk("t6_free_addr", rs.free_slot_addr_out, 0);
        chk("t6_err_kept", err, 1);
        cdb(44);
        step();
        step();
        chk("t6_no_stale_issue", rs.issue_valid_out, 0);

        // Write/CDB bypass on src2
        rs.issue_ready_in = 1;
        wr(0, 3, 0, 7, 1, 4);
        cdb(7);
        step();
        step();
        chk("t5_issue_valid", rs.issue_valid_out, 1);
        chk("t5_issue_rob", rs.issue_rob_tag_out, 4);

        // Asynchronous reset in the middle of activity
        wr(1, 5, 1, 0, 0, 9);
        step();
        #3;
        rst = 1;
        #1;
        model_reset();
        check_reset_values("async_rst");
        @(negedge clk);
        rst = 0;

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            head = rob_addr_t'($urandom_range(0, ROB_SIZE - 1));
            rs.issue_ready_in = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                fa = int'(rs.free_slot_addr_out);
                if ($urandom_range(0, 49) == 0) fa = $urandom_range(0, RES_ST_SIZE - 1);
                if (rs.free_slot_valid_out || fa != int'(rs.free_slot_addr_out))
                    wr(fa, $urandom_range(0, 7), $urandom_range(0, 1),
                       $urandom_range(0, 7), $urandom_range(0, 1),
                       $urandom_range(0, ROB_SIZE - 1));
            end
            if ($urandom_range(0, 1) == 1) cdb($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) flush = 1;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
